// File: rtl/search_result_bcd.sv
// Search-result display path: captures a match address, times the search in clock
// cycles, and converts the selected value to BCD with a serial double-dabble engine.
module search_result_bcd #(
    parameter int WIDTH     = 16,
    parameter int DIGITS    = 4,
    parameter int CNT_WIDTH = 16
) (
    input  logic                  CLK100MHZ,
    input  logic                  reset,
    input  logic                  start,
    input  logic                  result_valid,
    input  logic [WIDTH-1:0]      result,
    input  logic                  mode,
    output logic [4*DIGITS-1:0]   bcd_out,
    output logic [DIGITS-1:0]     blank_mask,
    output logic                  overflow,
    output logic                  busy,
    output logic                  bcd_valid,
    output logic [CNT_WIDTH-1:0]  elapsed
);

    localparam int SCR_BASE   = (WIDTH + 2) / 3 + 1;
    localparam int SCR_DIGITS = (SCR_BASE > DIGITS) ? SCR_BASE : DIGITS;
    localparam int SCR_W      = 4 * SCR_DIGITS;
    localparam int BIT_CNT_W  = $clog2(WIDTH + 1);

    typedef enum logic [1:0] {IDLE, LOAD, SHIFT, DONE} state_t;

    function automatic logic [SCR_W-1:0] dabble_step(input logic [SCR_W-1:0] scr,
                                                     input logic            msb);
        logic [SCR_W-1:0] adj;
        adj = scr;
        for (int i = 0; i < SCR_DIGITS; i++) begin
            if (adj[4*i +: 4] >= 4'd5)
                adj[4*i +: 4] = adj[4*i +: 4] + 4'd3;
        end
        return {adj[SCR_W-2:0], msb};
    endfunction

    // Any nonzero digit beyond the displayed ones means the value does not fit.
    function automatic logic scr_overflow(input logic [SCR_W-1:0] scr);
        logic ovf;
        ovf = 1'b0;
        for (int i = DIGITS; i < SCR_DIGITS; i++) begin
            if (scr[4*i +: 4] != 4'd0)
                ovf = 1'b1;
        end
        return ovf;
    endfunction

    function automatic logic [DIGITS-1:0] lead_blank(input logic [4*DIGITS-1:0] d);
        logic [DIGITS-1:0] m;
        logic              all_zero;
        m        = '0;
        all_zero = 1'b1;
        for (int i = DIGITS - 1; i >= 1; i--) begin
            if (d[4*i +: 4] != 4'd0)
                all_zero = 1'b0;
            m[i] = all_zero;
        end
        return m;
    endfunction

    state_t                 state_q;
    logic [CNT_WIDTH-1:0]   cnt_q;
    logic                   running_q;
    logic [WIDTH-1:0]       cap_q;
    logic                   mode_last_q;
    logic                   pending_q;
    logic                   busy_q;
    logic                   bcd_valid_q;
    logic [4*DIGITS-1:0]    bcd_q;
    logic [DIGITS-1:0]      blank_q;
    logic                   ovf_q;
    logic [BIT_CNT_W-1:0]   bit_cnt_q;
    logic [WIDTH-1:0]       src_q;
    logic [SCR_W-1:0]       scr_q;

    logic [WIDTH-1:0]       cnt_ext;
    logic                   trigger;
    logic                   busy_event;
    logic                   scr_ovf;
    logic [4*DIGITS-1:0]    scr_digits;

    always_comb begin
        cnt_ext                  = '0;
        cnt_ext[CNT_WIDTH-1:0]   = cnt_q;
    end

    assign trigger    = result_valid | (mode != mode_last_q) | (mode & running_q) | pending_q;
    assign busy_event = result_valid | (mode != mode_last_q);
    assign scr_ovf    = scr_overflow(scr_q);
    assign scr_digits = scr_q[4*DIGITS-1:0];

    // Elapsed counter: start wins, a result freezes after its own increment.
    always_ff @(posedge CLK100MHZ or negedge reset) begin
        if (!reset) begin
            cnt_q     <= '0;
            running_q <= 1'b0;
        end else if (start) begin
            cnt_q     <= '0;
            running_q <= ~result_valid;
        end else if (running_q) begin
            if (cnt_q != {CNT_WIDTH{1'b1}})
                cnt_q <= cnt_q + 1'b1;
            if (result_valid)
                running_q <= 1'b0;
        end
    end

    always_ff @(posedge CLK100MHZ or negedge reset) begin
        if (!reset) begin
            state_q     <= IDLE;
            cap_q       <= '0;
            mode_last_q <= 1'b0;
            pending_q   <= 1'b0;
            busy_q      <= 1'b0;
            bcd_valid_q <= 1'b0;
            bcd_q       <= '0;
            blank_q     <= {{(DIGITS-1){1'b1}}, 1'b0};
            ovf_q       <= 1'b0;
            bit_cnt_q   <= '0;
        end else begin
            bcd_valid_q <= 1'b0;
            if (result_valid)
                cap_q <= result;
            case (state_q)
                IDLE: begin
                    if (trigger) begin
                        busy_q  <= 1'b1;
                        state_q <= LOAD;
                    end
                end
                LOAD: begin
                    mode_last_q <= mode;
                    pending_q   <= result_valid;
                    bit_cnt_q   <= '0;
                    state_q     <= SHIFT;
                end
                SHIFT: begin
                    if (busy_event)
                        pending_q <= 1'b1;
                    bit_cnt_q <= bit_cnt_q + 1'b1;
                    if (bit_cnt_q == BIT_CNT_W'(WIDTH - 1))
                        state_q <= DONE;
                end
                DONE: begin
                    if (busy_event)
                        pending_q <= 1'b1;
                    ovf_q       <= scr_ovf;
                    bcd_q       <= scr_ovf ? {DIGITS{4'h9}} : scr_digits;
                    blank_q     <= scr_ovf ? '0 : lead_blank(scr_digits);
                    bcd_valid_q <= 1'b1;
                    busy_q      <= 1'b0;
                    state_q     <= IDLE;
                end
                default: state_q <= IDLE;
            endcase
        end
    end

    // Conversion datapath: contents only matter between LOAD and DONE.
    always_ff @(posedge CLK100MHZ) begin
        if (state_q == LOAD) begin
            src_q <= mode ? cnt_ext : cap_q;
            scr_q <= '0;
        end else if (state_q == SHIFT) begin
            scr_q <= dabble_step(scr_q, src_q[WIDTH-1]);
            src_q <= {src_q[WIDTH-2:0], 1'b0};
        end
    end

    assign bcd_out    = bcd_q;
    assign blank_mask = blank_q;
    assign overflow   = ovf_q;
    assign busy       = busy_q;
    assign bcd_valid  = bcd_valid_q;
    assign elapsed    = cnt_q;

endmodule

// File: tb/tb_search_result_bcd.sv
// Directed bench for search_result_bcd: latency, digits, blanking, overflow,
// elapsed timing, back-to-back results, mode toggles and mid-conversion reset.
module tb_search_result_bcd;

    logic        clk = 1'b0;
    logic        reset;
    logic        start;
    logic        result_valid;
    logic [15:0] result;
    logic        mode;
    logic [15:0] bcd_out;
    logic [3:0]  blank_mask;
    logic        overflow;
    logic        busy;
    logic        bcd_valid;
    logic [15:0] elapsed;

    int total = 0;
    int bad   = 0;

    search_result_bcd #(.WIDTH(16), .DIGITS(4), .CNT_WIDTH(16)) dut (
        .CLK100MHZ    (clk),
        .reset        (reset),
        .start        (start),
        .result_valid (result_valid),
        .result       (result),
        .mode         (mode),
        .bcd_out      (bcd_out),
        .blank_mask   (blank_mask),
        .overflow     (overflow),
        .busy         (busy),
        .bcd_valid    (bcd_valid),
        .elapsed      (elapsed)
    );

    always #5 clk = ~clk;

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    // Pulse result_valid on the next edge, then count edges until bcd_valid (-1 on timeout).
    task automatic run_conv(input logic [15:0] val, output int n);
        result       = val;
        result_valid = 1'b1;
        tick();
        result_valid = 1'b0;
        n = -1;
        for (int i = 1; i <= 60; i++) begin
            tick();
            if (bcd_valid === 1'b1) begin
                n = i;
                break;
            end
        end
    endtask

    task automatic test_reset();
        reset = 1'b0; start = 1'b0; result_valid = 1'b0; result = '0; mode = 1'b0;
        repeat (3) tick();
        total++; if (bcd_out !== 16'h0000) begin bad++; $display("FAIL reset_bcd got=%h want=0000", bcd_out); end
        total++; if (blank_mask !== 4'b1110) begin bad++; $display("FAIL reset_blank got=%b want=1110", blank_mask); end
        total++; if (overflow !== 1'b0) begin bad++; $display("FAIL reset_ovf got=%b want=0", overflow); end
        total++; if (busy !== 1'b0) begin bad++; $display("FAIL reset_busy got=%b want=0", busy); end
        total++; if (bcd_valid !== 1'b0) begin bad++; $display("FAIL reset_valid got=%b want=0", bcd_valid); end
        total++; if (elapsed !== 16'd0) begin bad++; $display("FAIL reset_elapsed got=%0d want=0", elapsed); end
        reset = 1'b1;
        repeat (2) tick();
    endtask

    task automatic test_basic();
        int n;
        result       = 16'd1234;
        result_valid = 1'b1;
        tick();
        result_valid = 1'b0;
        total++; if (busy !== 1'b1) begin bad++; $display("FAIL basic_busy got=%b want=1", busy); end
        n = -1;
        for (int i = 1; i <= 60; i++) begin
            tick();
            if (bcd_valid === 1'b1) begin n = i; break; end
            if (bcd_out !== 16'h0000) begin
                total++; bad++; $display("FAIL basic_hold got=%h want=0000", bcd_out);
                break;
            end
        end
        total++; if (n != 18) begin bad++; $display("FAIL basic_latency got=%0d want=18", n); end
        total++; if (bcd_out !== 16'h1234) begin bad++; $display("FAIL basic_bcd got=%h want=1234", bcd_out); end
        total++; if (blank_mask !== 4'b0000) begin bad++; $display("FAIL basic_blank got=%b want=0000", blank_mask); end
        total++; if (overflow !== 1'b0) begin bad++; $display("FAIL basic_ovf got=%b want=0", overflow); end
        total++; if (busy !== 1'b0) begin bad++; $display("FAIL basic_busy_done got=%b want=0", busy); end
        tick();
        total++; if (bcd_valid !== 1'b0) begin bad++; $display("FAIL basic_pulse got=%b want=0", bcd_valid); end
    endtask

    task automatic test_small();
        int n;
        run_conv(16'd7, n);
        total++; if (n != 18) begin bad++; $display("FAIL small7_latency got=%0d want=18", n); end
        total++; if (bcd_out !== 16'h0007) begin bad++; $display("FAIL small7_bcd got=%h want=0007", bcd_out); end
        total++; if (blank_mask !== 4'b1110) begin bad++; $display("FAIL small7_blank got=%b want=1110", blank_mask); end
        tick();
        run_conv(16'd0, n);
        total++; if (bcd_out !== 16'h0000) begin bad++; $display("FAIL zero_bcd got=%h want=0000", bcd_out); end
        total++; if (blank_mask !== 4'b1110) begin bad++; $display("FAIL zero_blank got=%b want=1110", blank_mask); end
        tick();
    endtask

    task automatic test_overflow();
        int n;
        run_conv(16'd12345, n);
        total++; if (overflow !== 1'b1) begin bad++; $display("FAIL ovf_flag got=%b want=1", overflow); end
        total++; if (bcd_out !== 16'h9999) begin bad++; $display("FAIL ovf_bcd got=%h want=9999", bcd_out); end
        total++; if (blank_mask !== 4'b0000) begin bad++; $display("FAIL ovf_blank got=%b want=0000", blank_mask); end
        tick();
        run_conv(16'd9999, n);
        total++; if (overflow !== 1'b0) begin bad++; $display("FAIL max_flag got=%b want=0", overflow); end
        total++; if (bcd_out !== 16'h9999) begin bad++; $display("FAIL max_bcd got=%h want=9999", bcd_out); end
        tick();
        run_conv(16'd65535, n);
        total++; if (overflow !== 1'b1) begin bad++; $display("FAIL full_flag got=%b want=1", overflow); end
        tick();
    endtask

    task automatic test_elapsed();
        logic [15:0] last_bcd;
        logic [3:0]  last_blank;
        int          pulses;
        mode  = 1'b1;
        start = 1'b1;
        tick();
        start = 1'b0;
        for (int e = 1; e <= 49; e++) begin
            tick();
            if (e == 10) begin
                total++; if (elapsed !== 16'd10) begin bad++; $display("FAIL elapsed_run got=%0d want=10", elapsed); end
            end
        end
        result       = 16'd0;
        result_valid = 1'b1;
        tick();
        result_valid = 1'b0;
        total++; if (elapsed !== 16'd50) begin bad++; $display("FAIL elapsed_stop got=%0d want=50", elapsed); end
        last_bcd = 16'hFFFF; last_blank = 4'hF; pulses = 0;
        for (int i = 0; i < 80; i++) begin
            tick();
            if (bcd_valid === 1'b1) begin
                pulses++;
                last_bcd   = bcd_out;
                last_blank = blank_mask;
            end
        end
        total++; if (pulses < 1) begin bad++; $display("FAIL elapsed_pulse got=%0d want>=1", pulses); end
        total++; if (last_bcd !== 16'h0050) begin bad++; $display("FAIL elapsed_bcd got=%h want=0050", last_bcd); end
        total++; if (last_blank !== 4'b1100) begin bad++; $display("FAIL elapsed_blank got=%b want=1100", last_blank); end
        total++; if (elapsed !== 16'd50) begin bad++; $display("FAIL elapsed_frozen got=%0d want=50", elapsed); end
        mode = 1'b0;
        repeat (30) tick();
    endtask

    task automatic test_back_to_back();
        logic [15:0] vals [2];
        logic [3:0]  blks [2];
        int          pulses;
        pulses = 0;
        vals[0] = '0; vals[1] = '0; blks[0] = '0; blks[1] = '0;
        for (int k = 0; k < 60; k++) begin
            result_valid = (k == 0) || (k == 5);
            result       = (k == 5) ? 16'd42 : 16'd300;
            tick();
            if (bcd_valid === 1'b1) begin
                if (pulses < 2) begin vals[pulses] = bcd_out; blks[pulses] = blank_mask; end
                pulses++;
            end
        end
        result_valid = 1'b0;
        total++; if (pulses != 2) begin bad++; $display("FAIL b2b_pulses got=%0d want=2", pulses); end
        total++; if (vals[0] !== 16'h0300) begin bad++; $display("FAIL b2b_first got=%h want=0300", vals[0]); end
        total++; if (blks[0] !== 4'b1000) begin bad++; $display("FAIL b2b_first_blank got=%b want=1000", blks[0]); end
        total++; if (vals[1] !== 16'h0042) begin bad++; $display("FAIL b2b_second got=%h want=0042", vals[1]); end
        total++; if (blks[1] !== 4'b1100) begin bad++; $display("FAIL b2b_second_blank got=%b want=1100", blks[1]); end
    endtask

    task automatic test_mode_toggle();
        int          pulses;
        logic [15:0] last_bcd;
        pulses = 0; last_bcd = '0;
        for (int k = 0; k < 60; k++) begin
            result_valid = (k == 0);
            result       = 16'd555;
            mode         = (k >= 4) && (k < 6);
            tick();
            if (bcd_valid === 1'b1) begin
                pulses++;
                last_bcd = bcd_out;
            end
        end
        result_valid = 1'b0;
        mode = 1'b0;
        total++; if (pulses != 2) begin bad++; $display("FAIL toggle_pulses got=%0d want=2", pulses); end
        total++; if (last_bcd !== 16'h0555) begin bad++; $display("FAIL toggle_bcd got=%h want=0555", last_bcd); end
    endtask

    task automatic test_reset_mid();
        int n;
        int pulses;
        result       = 16'd4321;
        result_valid = 1'b1;
        tick();
        result_valid = 1'b0;
        repeat (9) tick();
        total++; if (busy !== 1'b1) begin bad++; $display("FAIL mid_busy got=%b want=1", busy); end
        reset = 1'b0;
        #1;
        total++; if (bcd_out !== 16'h0000) begin bad++; $display("FAIL mid_bcd got=%h want=0000", bcd_out); end
        total++; if (blank_mask !== 4'b1110) begin bad++; $display("FAIL mid_blank got=%b want=1110", blank_mask); end
        total++; if (busy !== 1'b0) begin bad++; $display("FAIL mid_busy_clr got=%b want=0", busy); end
        total++; if (elapsed !== 16'd0) begin bad++; $display("FAIL mid_elapsed got=%0d want=0", elapsed); end
        pulses = 0;
        for (int i = 0; i < 3; i++) begin
            tick();
            if (bcd_valid !== 1'b0) pulses++;
        end
        reset = 1'b1;
        for (int i = 0; i < 30; i++) begin
            tick();
            if (bcd_valid !== 1'b0) pulses++;
        end
        total++; if (pulses != 0) begin bad++; $display("FAIL mid_no_valid got=%0d want=0", pulses); end
        run_conv(16'd4321, n);
        total++; if (n != 18) begin bad++; $display("FAIL after_latency got=%0d want=18", n); end
        total++; if (bcd_out !== 16'h4321) begin bad++; $display("FAIL after_bcd got=%h want=4321", bcd_out); end
        total++; if (blank_mask !== 4'b0000) begin bad++; $display("FAIL after_blank got=%b want=0000", blank_mask); end
    endtask

    initial begin
        test_reset();
        test_basic();
        test_small();
        test_overflow();
        test_elapsed();
        test_back_to_back();
        test_mode_toggle();
        test_reset_mid();
        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end

endmodule

// File: doc/search_result_bcd.md
Name: search_result_bcd

Overview:
- Sequential successor to the ad-hoc binary-to-digit split on the search-result path.
- Captures a search result and measures the search latency in clock cycles.
- Converts the selected value to BCD with a multi-cycle double-dabble engine.
- Presents registered digits, leading-zero blanking and an overflow flag to the seven-segment driver.

Parameters:
- WIDTH, 16: width of the result input and of the binary value converted.
- DIGITS, 4: number of BCD digits presented (bcd_out is 4*DIGITS bits).
- CNT_WIDTH, 16: width of the elapsed-cycle counter; must be <= WIDTH.

Ports:
- CLK100MHZ  in  1  system clock, rising edge.
- reset  in  1  asynchronous, active-low reset.
- start  in  1  1-cycle pulse at search launch; clears and starts the elapsed counter.
- result_valid  in  1  1-cycle pulse; result is valid this cycle.
- result  in  WIDTH  binary search result (match address).
- mode  in  1  display select: 0 = captured result, 1 = elapsed cycles.
- bcd_out  out  4*DIGITS  BCD digits; digit 0 = bits [3:0] = units.
- blank_mask  out  DIGITS  1 = digit is a leading zero and is to be blanked.
- overflow  out  1  selected value > 10^DIGITS-1.
- busy  out  1  conversion in progress.
- bcd_valid  out  1  1-cycle pulse when bcd_out/blank_mask/overflow update.
- elapsed  out  CNT_WIDTH  current or frozen elapsed-cycle count.

Behaviour:
- Reset (async assert, sync release):
  - bcd_out=0, blank_mask={DIGITS-1 ones, 0}, overflow=0, busy=0, bcd_valid=0, elapsed=0.
  - Counter stopped, captured result=0, pending=0, FSM in IDLE.
- Elapsed counter:
  - The edge sampling start loads 0 and sets running.
  - Each later edge increments; saturates at all-ones, no wrap.
  - The edge sampling result_valid performs its increment, then freezes the count.
  - So start at edge 0 and result_valid at edge N gives elapsed=N.
  - start and result_valid on the same edge: elapsed=0, frozen.
  - result_valid with counter stopped: count unchanged.
- Capture: result_valid registers result into the captured-result register in the same edge.
- FSM states: IDLE, LOAD, SHIFT, DONE.
  - IDLE->LOAD on a trigger. Triggers are:
    - result_valid;
    - mode differs from mode latched at the last LOAD;
    - mode=1 and counter running (live refresh);
    - pending=1.
  - LOAD (1 cycle): latch source per current mode, zero-extending elapsed to WIDTH; clear scratch; clear pending; busy=1.
  - SHIFT (exactly WIDTH cycles): add 3 to every scratch digit >=5, then shift left one bit bringing in source MSB first.
  - DONE (1 cycle):
    - Register bcd_out, blank_mask and overflow; pulse bcd_valid; busy=0; go to IDLE.
    - Trigger-to-bcd_valid latency is WIDTH+2 edges.
- Scratch and overflow:
  - Scratch holds ceil(WIDTH/3)+1 digits.
  - overflow=1 if any scratch digit above index DIGITS-1 is nonzero.
  - When overflow=1: bcd_out = all digits 9 and blank_mask=0.
- Blanking:
  - blank_mask[i]=1 iff digit i and every higher digit are 0, for i>=1.
  - blank_mask[0] is always 0.
- Outputs hold their previous values throughout a conversion; no intermediate values are visible.
- Events while busy:
  - result_valid: captured and pending set; one-deep, latest value wins.
  - mode change: sets pending.
  - start: resets the counter; the current conversion completes unaffected.
- Pending is serviced from IDLE on the edge after DONE.
- Reset mid-conversion aborts immediately to reset values; no bcd_valid is issued.

Test Plan (WIDTH=16, DIGITS=4, CNT_WIDTH=16):
1. result=1234 with result_valid, mode=0 -> bcd_valid exactly 18 edges later; bcd_out=0x1234, blank_mask=0000, overflow=0.
2. result=7, then result=0 (separate conversions) -> 0x0007 with blank 1110; then 0x0000 with blank 1110.
3. result=12345 -> overflow=1, bcd_out=0x9999, blank 0000; then result=9999 -> overflow=0, bcd_out=0x9999.
4. start at edge 0, result_valid at edge 50, mode=1 -> elapsed=50; final bcd_out=0x0050, blank 1100.
5. Boundary handling:
   - result_valid 300, then 42 five cycles later, mode=0 -> two bcd_valid pulses: 0x0300 (blank 1000), then 0x0042 (blank 1100).
   - Toggling mode during a conversion -> one extra conversion follows.
6. Reset:
   - reset low at SHIFT cycle 8 of result=4321 -> outputs return to reset values immediately; no bcd_valid.
   - After release, a fresh result_valid 4321 -> 0x4321.
